iterative_multiplier: RTL and testbench

- Parametrised multi-bit-per-cycle shift-add multiplier. Successor to the single-bit iterative multiplier.
- Implements all four RV32M multiply flavours (MUL, MULH, MULHSU, MULHU).
- Uses valid/ready handshakes, a pass-through tag and flush support, so it can sit behind the execute-stage reservation station of the OoO core and return results to the CDB arbiter.

---
 rtl/iterative_multiplier.sv | 172 +++++++++++++++++
 tb/tb_iterative_multiplier.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_multiplier.sv
// Multi-bit-per-cycle shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops.
// Define ITER_MUL_EARLY_TERM_EN to finish early once the remaining multiplier bits are zero.
module iterative_multiplier #(
  parameter int unsigned OPERAND_WIDTH  = 32,
  parameter int unsigned BITS_PER_CYCLE = 2,
  parameter int unsigned TAG_WIDTH      = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [OPERAND_WIDTH-1:0] in_a,
  input  logic [OPERAND_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic                     busy
);

  localparam int unsigned W     = OPERAND_WIDTH;
  localparam int unsigned K     = BITS_PER_CYCLE;
  localparam int unsigned PW    = 2 * W;
  localparam int unsigned STEPS = W / K;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [PW-1:0]        a_q, a_d;
  logic [W:0]           b_q, b_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [W-1:0]         res_q, res_d;
  logic [TAG_WIDTH-1:0] otag_q, otag_d;
  logic                 in_ready_q, out_valid_q, busy_q;

  // Operand magnitude extraction for the accept cycle
  logic       a_signed, b_signed, a_neg, b_neg;
  logic [W:0] a_sx, b_sx, a_mag, b_mag;

  always_comb begin
    a_signed = (in_op != 2'b11);
    b_signed = ~in_op[1];
    a_neg    = a_signed & in_a[W-1];
    b_neg    = b_signed & in_b[W-1];
    a_sx     = {a_neg, in_a};
    b_sx     = {b_neg, in_b};
    a_mag    = a_neg ? (~a_sx + (W+1)'(1)) : a_sx;
    b_mag    = b_neg ? (~b_sx + (W+1)'(1)) : b_sx;
  end

  // K-bit partial product by shift-and-add, then signed finalisation
  logic [PW-1:0] pp, acc_sum, prod;
  logic [W-1:0]  fin_result;
  logic          early, last, fin;

`ifdef ITER_MUL_EARLY_TERM_EN
  assign early = (b_q == '0);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    pp = '0;
    for (int unsigned j = 0; j < K; j++) begin
      if (b_q[j]) pp = pp + (a_q << j);
    end
    acc_sum    = acc_q + pp;
    prod       = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
    fin_result = (op_q == 2'b00) ? prod[W-1:0] : prod[PW-1:W];
    last       = (cnt_q == CW'(STEPS - 1));
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    otag_d  = otag_q;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          tag_d   = in_tag;
          a_d     = {{(W-1){1'b0}}, a_mag};
          b_d     = b_mag;
          neg_d   = (a_neg ^ b_neg) & (in_a != '0) & (in_b != '0);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = a_q << K;
        b_d   = b_q >> K;
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
        if (last || early) begin
          fin     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // flush overrides every transition and suppresses the result load
    if (flush) begin
      state_d = IDLE;
    end else if (fin) begin
      res_d  = fin_result;
      otag_d = tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      tag_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      otag_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      otag_q      <= otag_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign out_result = res_q;
  assign out_tag    = otag_q;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Randomised self-checking bench for iterative_multiplier against a 64-bit arithmetic model.
module tb_iterative_multiplier;

  localparam int unsigned W     = 32;
  localparam int unsigned K     = 2;
  localparam int unsigned TW    = 6;
  localparam int unsigned STEPS = W / K;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = 2'b00;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          busy;

  int checks = 0;
  int failures = 0;

  logic          exp_pending = 1'b0;
  logic [W-1:0]  exp_res = '0;
  logic [TW-1:0] exp_tag = '0;

  always #5 clk = ~clk;

  iterative_multiplier #(
    .OPERAND_WIDTH (W),
    .BITS_PER_CYCLE(K),
    .TAG_WIDTH     (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Reference: full 64-bit product of the operands interpreted per op
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [63:0] pa, pb, p;
    pa = (op != 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
    pb = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = pa * pb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Cycles from the accept cycle to the first out_valid cycle
  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
`ifdef ITER_MUL_EARLY_TERM_EN
    longint bv;
    int     bits;
    int     cyc;
    bv = longint'(b);
    if (op[1] == 1'b0 && b[31]) bv = bv - 64'sh1_0000_0000;
    if (bv < 0) bv = -bv;
    bits = 0;
    while (bv != 0) begin
      bits++;
      bv = bv >> 1;
    end
    cyc = (bits + int'(K) - 1) / int'(K) + 1;
    if (cyc > int'(STEPS)) cyc = int'(STEPS);
    return cyc + 1;
`else
    return int'(STEPS) + 1;
`endif
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'(W'($urandom_range(0, 15)));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input int hold, output logic [W-1:0] got);
    int            lat;
    logic [W-1:0]  r0;
    logic [TW-1:0] t0;
    @(posedge clk); #1;
    check("ready_before_issue", 64'(in_ready), 64'd1);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_op = 2'($urandom); in_tag = TW'($urandom);
    exp_res = model(op, a, b); exp_tag = tag; exp_pending = 1'b1;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat(op, b)));
    got = out_result;
    r0 = out_result;
    t0 = out_tag;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(out_result), 64'(r0));
      check("hold_tag", 64'(out_tag), 64'(t0));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_pending = 1'b0;
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] got;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    int           seen;

    // Per-cycle output compare against the outstanding expected result
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (out_valid) begin
            check("mon_valid_expected", 64'(exp_pending), 64'd1);
            check("mon_result", 64'(out_result), 64'(exp_res));
            check("mon_tag", 64'(out_tag), 64'(exp_tag));
          end
          check("mon_ready_vs_busy", 64'(in_ready), 64'(!busy));
        end
      end
    join_none

    check("model_mulhu_max", 64'(model(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFE);
    check("model_mul_neg", 64'(model(2'b00, 32'hFFFF_FFFD, 32'd7)), 64'hFFFF_FFEB);
    check("model_mulh_min", 64'(model(2'b01, 32'h8000_0000, 32'h8000_0000)), 64'h4000_0000);

    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;

    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd5, 0, got);
    check("mulhu_max", 64'(got), 64'hFFFF_FFFE);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 6'd1, 0, got);
    check("mul_neg3x7", 64'(got), 64'hFFFF_FFEB);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 6'd2, 1, got);
    check("mulh_neg3x7", 64'(got), 64'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'd2, 6'd3, 0, got);
    check("mulhsu_min_x2", 64'(got), 64'hFFFF_FFFF);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 6'd4, 0, got);
    check("mulh_min_min", 64'(got), 64'h4000_0000);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd6, 0, got);
    check("mul_min_neg1", 64'(got), 64'h8000_0000);
    run_op(2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 6'd7, 0, got);
    check("mulh_zero", 64'(got), 64'h0);
    run_op(2'b00, 32'd12345, 32'd678, 6'h2F, 10, got);
    check("backpressure_result", 64'(got), 64'd8369910);

    // Flush during CALC cycle 5: the request must never complete
    @(posedge clk); #1;
    in_op = 2'b01; in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_tag = 6'h2A; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_valid", 64'(seen), 64'd0);

    // Request coincident with flush is dropped
    in_op = 2'b00; in_a = 32'd3; in_b = 32'd4; in_tag = 6'h11; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_drops_req", 64'(busy), 64'd0);

    run_op(2'b10, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 6'h15, 0, got);
    check("after_flush_mulhsu", 64'(got), 64'hFFFF_FFFE);

    // Asynchronous reset mid-CALC
    @(posedge clk); #1;
    in_op = 2'b11; in_a = 32'hDEAD_BEEF; in_b = 32'hCAFE_F00D; in_tag = 6'h3C; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom);
      ra  = pick();
      rb  = pick();
      run_op(rop, ra, rb, TW'($urandom), int'($urandom_range(0, 3)), got);
    end

`ifdef ITER_MUL_EARLY_TERM_EN
    run_op(2'b11, 32'd123, 32'd0, 6'd9, 0, got);
    check("early_b0", 64'(got), 64'd0);
    check("early_b0_lat", 64'(exp_lat(2'b11, 32'd0)), 64'd2);
    run_op(2'b11, 32'd123, 32'd3, 6'd10, 0, got);
    check("early_b3", 64'(got), 64'd0);
    check("early_b3_lat", 64'(exp_lat(2'b11, 32'd3)), 64'd3);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
